regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side front end for the 32×64 integer register file: it owns the single register-file write port (RegWrite/WriteReg/WriteData). It merges single-cycle ALU results with multi-cycle load results, buffers loads in a small FIFO, and serializes them onto the port. It also keeps a pending-load scoreboard, which the decode stage queries for RAW hazards.

## Interface
Parameters:
- DATA_W, 64, result/data width
- DEPTH, 4, load-result FIFO entries (power of 2, ≥2)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low
- alu_valid  input  1  ALU result present this cycle; always accepted
- alu_rd  input  5  ALU destination register
- alu_data  input  DATA_W  ALU result
- ld_valid  input  1  load result offered
- ld_ready  output  1  load result accepted when ld_valid && ld_ready
- ld_rd  input  5  load destination register
- ld_data  input  DATA_W  load result
- pend_set  input  1  a load has issued; mark pend_rd pending
- pend_rd  input  5  destination of the issuing load
- chk_rs1, chk_rs2  input  5 each  decode-stage source registers
- hazard1, hazard2  output  1 each  source has a pending load
- fwd1_valid, fwd2_valid  output  1 each  forwarded value available
- fwd1_data, fwd2_data  output  DATA_W each  forwarded value
- RegWrite  output  1  register-file write enable
- WriteReg  output  5  register-file write address
- WriteData  output  DATA_W  register-file write data
- occupancy  output  $clog2(DEPTH)+1  FIFO entry count

## Operation
- Write-port arbitration, evaluated every cycle:
  - alu_valid with alu_rd≠0: the ALU result wins.
  - Otherwise, if the FIFO is non-empty: pop the head and write it.
  - Otherwise: RegWrite=0.
- A load blocked by the ALU stays at the FIFO head. There is no age-based fairness; the ALU always has priority.
- Writes to x0 are discarded. An alu_rd=0 write produces no write and lets the FIFO drain in that cycle. An ld_rd=0 load is accepted (handshake completes) but is not enqueued.
- ld_ready = !full while rst=1. ld_ready=0 while rst=0.
- Push and pop in the same cycle are legal when full. ld_ready still reflects the current cycle's full flag, so no push happens when full, even if a pop occurs.
- Scoreboard: 32-bit busy vector; bit 0 is hard-wired to 0.
  - pend_set sets busy[pend_rd].
  - Emitting a load write to register r clears busy[r].
  - Set and clear of the same register in the same cycle: the set wins.
- hazard1 = busy[chk_rs1]; hazard2 = busy[chk_rs2]. Both are combinational.
- FIFO pointers wrap modulo DEPTH. occupancy ranges 0..DEPTH.

## Timing
- Write port is registered: a result selected in cycle N appears on RegWrite/WriteReg/WriteData in cycle N+1 for exactly one cycle. Latency is therefore 1 cycle for an ALU result and ≥2 cycles for a load (push, then pop, then output).
- After rst=0 at a clock edge:
  - RegWrite=0, WriteReg=0, WriteData=0.
  - FIFO empty, occupancy=0, busy=0.
  - hazard*=0, fwd*_valid=0, fwd*_data=0.
- Reset mid-operation discards queued loads and pending marks; no write for a discarded entry is ever emitted.
- With the FIFO empty and no ALU write, an accepted load is written 2 cycles after acceptance. There is no same-cycle FIFO bypass.

## Configuration
- REGFILE_WB_FWD_EN defined:
  - fwdN_valid=1 when chk_rsN≠0 matches either the registered output stage (RegWrite && WriteReg) or any valid FIFO entry.
  - Priority: the youngest FIFO entry first, then the output stage.
  - fwdN_data is the matching data.
  - A forwarded source still asserts hazardN; the consumer decides.
- Not defined: fwdN_valid=0 and fwdN_data=0 permanently. Ports remain present and no comparators are built.

## Structure
- Shared package wb_pkg:
  - DATA_W default
  - REG_ADDR_W=5
  - wb_entry_t {rd[4:0], data[DATA_W-1:0]}
  - X0 constant
- Sub-module wb_fifo:
  - parameterized synchronous FIFO of wb_entry_t
  - push/pop/full/empty/count
  - read/write of all entries exposed for the forwarding search
- Top level contains the arbiter, output register, and scoreboard.

## Test plan
- Reset check: hold rst=0 for 2 cycles with traffic on all inputs.
  - Required: RegWrite=0, ld_ready=0, occupancy=0, hazard1=hazard2=0.
- ALU only: alu_valid, alu_rd=5, alu_data=0x1234 in cycle N.
  - Required: RegWrite=1, WriteReg=5, WriteData=0x1234 in cycle N+1 only.
- Contention: load (rd=7, 0xAA) accepted in cycle N; alu_valid (rd=3) in cycles N+1..N+3.
  - Required: three ALU writes to x3, then the write to x7 (0xAA) in cycle N+5.
- Full FIFO: with the ALU saturating the port, DEPTH=4 loads fill the FIFO.
  - Required: ld_ready=0 with occupancy=4; after the ALU stops, the four writes emerge in FIFO order with ld_ready=1 again.
- Scoreboard:
  - pend_set rd=9 gives hazard1=1 for chk_rs1=9 until the load write to x9 is emitted.
  - Same-cycle new pend_set rd=9 keeps the bit set.
  - chk_rs1=0 always gives 0.
- x0 and forwarding: a load with rd=0 is accepted but never written. With REGFILE_WB_FWD_EN, queued entries rd=4=0x11 then rd=4=0x22 give fwd1_data=0x22 for chk_rs1=4.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, x0 constant and the queued write-back entry type.
package wb_pkg;
    localparam int DATA_W = 64;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-result FIFO; exposes all entries oldest-first for forwarding.
module wb_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_pkg::wb_entry_t pushEntry,
    input  logic              pop,
    output wb_pkg::wb_entry_t popEntry,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output wb_pkg::wb_entry_t entries [DEPTH],
    output logic [DEPTH-1:0]  entryValid
);
    import wb_pkg::*;
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign popEntry = mem[rdPtr];
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushEntry;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
    // index 0 is the head, so higher indices are younger
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rdPtr + PW'(i)];
            entryValid[i] = CW'(i) < count;
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: ALU/load write-port arbiter with load scoreboard; forwarding via REGFILE_WB_FWD_EN.
module regfile_writeback #(
    parameter int DATA_W = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     pend_set,
    input  logic [4:0]               pend_rd,
    input  logic [4:0]               chk_rs1,
    input  logic [4:0]               chk_rs2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     fwd1_valid,
    output logic                     fwd2_valid,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic [DATA_W-1:0]        fwd2_data,
    output logic                     RegWrite,
    output logic [4:0]               WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    output logic [$clog2(DEPTH):0]   occupancy
);
    import wb_pkg::*;
    wb_entry_t head;
    logic full, empty, push, pop, aluWins;
    logic [31:0] busy, busyNext;
    assign ld_ready = rst && !full;
    assign aluWins = alu_valid && alu_rd != X0;
    assign push = ld_valid && ld_ready && ld_rd != X0;
    assign pop = !aluWins && !empty;
`ifdef REGFILE_WB_FWD_EN
    wb_entry_t entries [DEPTH];
    logic [DEPTH-1:0] entryValid;
`endif
    wb_fifo #(.DEPTH(DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pushEntry('{rd: ld_rd, data: ld_data}),
        .pop(pop),
        .popEntry(head),
        .full(full),
        .empty(empty),
        .count(occupancy),
`ifdef REGFILE_WB_FWD_EN
        .entries(entries),
        .entryValid(entryValid)
`else
        .entries(),
        .entryValid()
`endif
    );
    // a set in the same cycle as a clear wins; x0 never becomes busy
    assign busyNext = ((busy & ~(pop ? 32'b1 << head.rd : 32'b0))
                      | (pend_set ? 32'b1 << pend_rd : 32'b0)) & ~32'b1;
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWrite <= 1'b0;
            WriteReg <= X0;
            WriteData <= '0;
            busy <= '0;
        end else begin
            RegWrite <= aluWins || pop;
            WriteReg <= aluWins ? alu_rd : pop ? head.rd : X0;
            WriteData <= aluWins ? alu_data : pop ? head.data : '0;
            busy <= busyNext;
        end
    end
    assign hazard1 = busy[chk_rs1];
    assign hazard2 = busy[chk_rs2];
`ifdef REGFILE_WB_FWD_EN
    always_comb begin
        fwd1_valid = RegWrite && chk_rs1 != X0 && WriteReg == chk_rs1;
        fwd2_valid = RegWrite && chk_rs2 != X0 && WriteReg == chk_rs2;
        fwd1_data = fwd1_valid ? WriteData : '0;
        fwd2_data = fwd2_valid ? WriteData : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && chk_rs1 != X0 && entries[i].rd == chk_rs1) begin
                fwd1_valid = 1'b1;
                fwd1_data = entries[i].data;
            end
            if (entryValid[i] && chk_rs2 != X0 && entries[i].rd == chk_rs2) begin
                fwd2_valid = 1'b1;
                fwd2_data = entries[i].data;
            end
        end
    end
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vectors for the write-back arbiter, FIFO and scoreboard.
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst;
    logic alu_valid, ld_valid, pend_set;
    logic [4:0] alu_rd, ld_rd, pend_rd, chk_rs1, chk_rs2;
    logic [63:0] alu_data, ld_data;
    logic ld_ready, hazard1, hazard2, fwd1_valid, fwd2_valid, RegWrite;
    logic [63:0] fwd1_data, fwd2_data, WriteData;
    logic [4:0] WriteReg;
    logic [2:0] occupancy;
    int checks = 0;
    int errors = 0;

    regfile_writeback #(.DATA_W(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .pend_set(pend_set), .pend_rd(pend_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .hazard1(hazard1), .hazard2(hazard2),
        .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h2;
        pend_set = 1'b1; pend_rd = 5'd9;
        chk_rs1 = 5'd9; chk_rs2 = 5'd7;
        tick;
        tick;
        check("rst_regwrite", RegWrite, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_hazard1", hazard1, 0);
        check("rst_hazard2", hazard2, 0);
        check("rst_writedata", WriteData, 0);
        check("rst_fwd1_valid", fwd1_valid, 0);
        alu_valid = 1'b0; ld_valid = 1'b0; pend_set = 1'b0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        rst = 1'b1;
        tick;
        check("ready_after_rst", ld_ready, 1);

        // single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick;
        alu_valid = 1'b0;
        check("alu_regwrite", RegWrite, 1);
        check("alu_writereg", WriteReg, 5);
        check("alu_writedata", WriteData, 64'h1234);
        tick;
        check("alu_one_cycle", RegWrite, 0);

        // contention: load in N, ALU in N+1..N+3, load written in N+5
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'hAA;
        tick;
        ld_valid = 1'b0;
        check("cont_occ", occupancy, 1);
        check("cont_no_write", RegWrite, 0);
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h30 + 64'(k);
            tick;
            check("cont_alu_reg", WriteReg, 3);
            check("cont_alu_data", WriteData, 64'h30 + 64'(k));
        end
        alu_valid = 1'b0;
        tick;
        check("cont_ld_regwrite", RegWrite, 1);
        check("cont_ld_reg", WriteReg, 7);
        check("cont_ld_data", WriteData, 64'hAA);
        check("cont_occ_empty", occupancy, 0);
        tick;
        check("cont_idle", RegWrite, 0);

        // fill the FIFO while the ALU owns the port
        alu_valid = 1'b1; alu_rd = 5'd1;
        ld_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            alu_data = 64'h100 + 64'(k);
            ld_rd = 5'd10 + 5'(k); ld_data = 64'hB0 + 64'(k);
            tick;
        end
        ld_rd = 5'd14; ld_data = 64'hEE;
        check("full_occ", occupancy, 4);
        check("full_not_ready", ld_ready, 0);
        tick;
        check("full_no_push", occupancy, 4);
        check("full_alu_reg", WriteReg, 1);
        alu_valid = 1'b0; ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("drain_reg", WriteReg, 5'd10 + 5'(k));
            check("drain_data", WriteData, 64'hB0 + 64'(k));
            check("drain_ready", ld_ready, 1);
        end
        check("drain_occ", occupancy, 0);
        tick;
        check("drain_idle", RegWrite, 0);

        // scoreboard
        pend_set = 1'b1; pend_rd = 5'd9; chk_rs1 = 5'd9; chk_rs2 = 5'd0;
        tick;
        pend_set = 1'b0;
        check("sb_set", hazard1, 1);
        check("sb_x0_rs2", hazard2, 0);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99;
        tick;
        ld_valid = 1'b0;
        check("sb_queued", hazard1, 1);
        pend_set = 1'b1; pend_rd = 5'd9;
        tick;
        pend_set = 1'b0;
        check("sb_write_reg", WriteReg, 9);
        check("sb_write_data", WriteData, 64'h99);
        check("sb_set_wins", hazard1, 1);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h9A;
        tick;
        ld_valid = 1'b0;
        check("sb_still_busy", hazard1, 1);
        tick;
        check("sb_write2_data", WriteData, 64'h9A);
        check("sb_cleared", hazard1, 0);
        pend_set = 1'b1; pend_rd = 5'd0; chk_rs1 = 5'd0;
        tick;
        pend_set = 1'b0;
        check("sb_x0", hazard1, 0);

        // x0 load accepted but dropped
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'hDEAD;
        #1;
        check("x0_ready", ld_ready, 1);
        tick;
        ld_valid = 1'b0;
        check("x0_not_queued", occupancy, 0);
        tick;
        check("x0_no_write", RegWrite, 0);

        // ALU write to x0 lets the FIFO drain
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 64'h66;
        tick;
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hBAD;
        tick;
        alu_valid = 1'b0;
        check("alu_x0_reg", WriteReg, 6);
        check("alu_x0_data", WriteData, 64'h66);

        // forwarding: youngest queued entry, then output stage
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h555;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'h11;
        tick;
        ld_data = 64'h22;
        tick;
        ld_valid = 1'b0;
        chk_rs1 = 5'd4; chk_rs2 = 5'd1;
        #1;
        check("fwd_occ", occupancy, 2);
`ifdef REGFILE_WB_FWD_EN
        check("fwd1_valid", fwd1_valid, 1);
        check("fwd1_data", fwd1_data, 64'h22);
        check("fwd2_valid", fwd2_valid, 1);
        check("fwd2_data", fwd2_data, 64'h555);
`else
        check("fwd1_valid_off", fwd1_valid, 0);
        check("fwd1_data_off", fwd1_data, 0);
        check("fwd2_valid_off", fwd2_valid, 0);
        check("fwd2_data_off", fwd2_data, 0);
`endif
        alu_valid = 1'b0;
        tick;
        check("fwd_drain1", WriteData, 64'h11);
        tick;
        check("fwd_drain2", WriteData, 64'h22);
        tick;
        check("fwd_idle", RegWrite, 0);

        // reset mid-operation discards queue and pending marks
        alu_valid = 1'b1; alu_rd = 5'd1;
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 64'h88;
        pend_set = 1'b1; pend_rd = 5'd8; chk_rs1 = 5'd8;
        tick;
        check("mid_queued", occupancy, 1);
        alu_valid = 1'b0; ld_valid = 1'b0; pend_set = 1'b0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("mid_occ", occupancy, 0);
        check("mid_regwrite", RegWrite, 0);
        check("mid_hazard", hazard1, 0);
        tick;
        check("mid_no_write1", RegWrite, 0);
        tick;
        check("mid_no_write2", RegWrite, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
